conv_out_buffer: RTL and testbench
==================================

# conv_out_buffer

Downstream stage of the NPU convolution datapath. Consumes the 24-bit signed conv result stream (one result per valid pulse) and requantizes each result to 8 bits with optional ReLU, arithmetic right shift and saturation. Packs four bytes little-endian into 32-bit words and queues them in a synchronous FIFO that the host drains through the NPU read path. The host can therefore fetch a full packed word per bus read instead of polling every conv result.

## Interface

- DATA_W, 24, width of incoming signed conv result
- DEPTH, 32, FIFO depth in 32-bit words; power of two, ≥ 2
- SHIFT_W, 5, width of requant shift amount
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush-and-discard; highest priority after rst
- in_valid  in  1  conv result strobe, one result per cycle
- in_data  in  DATA_W  signed conv result
- relu_en  in  1  1: ReLU plus unsigned saturation [0,255]; 0: signed saturation [-128,127]
- shift  in  SHIFT_W  arithmetic right-shift amount applied after ReLU
- flush  in  1  push the partially filled word; unused lanes are zero
- rd_en  in  1  host pop request
- rd_data  out  32  popped word, registered
- rd_valid  out  1  one-cycle pulse, rd_data updated this cycle
- count  out  $clog2(DEPTH)+1  words currently in FIFO
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- lane_cnt  out  2  bytes held in the partial word
- overflow  out  1  sticky; a word was dropped on full

## Operation

- Requant (combinational on in_data): r = (relu_en && in_data<0) ? 0 : in_data. Then s = r >>> shift, full DATA_W width, sign-preserving. Then saturate s to [0,255] if relu_en, else to [-128,127] two's complement. Result is byte q.
- Pack: q is written to lane lane_cnt (lane 0 = bits [7:0], lane 3 = bits [31:24]), and lane_cnt increments and wraps 3→0.
- Push: occurs when in_valid and lane_cnt==3. It also occurs when flush and (lane_cnt!=0 or in_valid). If in_valid and flush coincide, the new byte is included in the flushed word.
- After any push, the partial word register and lane_cnt are zeroed. Flush with lane_cnt==0 and no in_valid is a no-op.
- Full handling: a push while full and no pop in the same cycle drops the word and sets overflow. overflow clears only on rst or clear.
- Pop: rd_en && !empty. The head word goes to rd_data, rd_valid pulses, and count decrements.
  - rd_en on empty is ignored: rd_valid=0 and rd_data holds.
- Simultaneous push and pop: both proceed and count is unchanged. This is valid when full: the word is accepted and overflow is not set. It is also valid when empty: the pop is ignored and the push proceeds.
- clear: FIFO empties, pointers go to 0, lane_cnt and partial word go to 0, overflow goes to 0. Inputs in the same cycle are discarded.
- Mid-operation rst: all state is discarded immediately.

## Timing

- Reset values: rd_data=0, rd_valid=0, count=0, empty=1, full=0, lane_cnt=0, overflow=0.
- in_valid sampled at edge E updates lane_cnt after E.
- A push at edge E updates count, empty and full after E. The word is poppable from cycle E+1.
- A pop at edge E updates rd_data, rd_valid and count after E, giving 1-cycle read latency.
- Sustained throughput is one in_valid per cycle, with concurrent pops every cycle.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. count has one extra bit to distinguish full from empty.

## Structure

- Shared package npu_pkg holds:
  - BYTE_W=8, WORD_W=32, LANES=4
  - U8_MAX=255, S8_MIN=-128, S8_MAX=127
  - a requant function (relu, shift, saturate) that can be reused by the conv2 path
- Sub-module npu_sync_fifo (WIDTH, DEPTH) contains the storage array, pointers, count, full/empty and registered read.
- conv_out_buffer contains the requant logic, lane packer, push logic and overflow flag.

## Test plan

- relu_en=1, shift=0; feed 5, -3, 300, 127 → one word 0x7FFF0005, count=1, lane_cnt=0.
- relu_en=0, shift=4; feed -4096, 256, -1, 2047 → word 0x7FFF1080.
- Feed 1, 2, then flush → word 0x00000201. A following flush with no data pushes nothing (count stays 1).
- Push 32 words, then push a 33rd without rd_en → full=1, overflow=1, 33rd dropped. Pop 32 → words in order 0..31, rd_valid each cycle, empty=1, then rd_en on empty gives rd_valid=0.
- With the FIFO full, a 4th in_valid coincides with rd_en → count stays 32, overflow stays 0, the new word is read last.
- Assert rst asynchronously with lane_cnt=2 and count=3 → all outputs at reset values before the next edge. Then clear with in_valid high → no byte captured.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU datapath constants and the 8-bit requantisation helper used by the
// conv output paths.
package npu_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   localparam int U8_MAX = 255;
   localparam int S8_MIN = -128;
   localparam int S8_MAX = 127;

   // Callers sign-extend their result to 32 bits first. For any shift up to 31
   // this gives the same byte as shifting the original narrower value.
   function automatic logic [BYTE_W-1:0] requant(
      input logic signed [31:0] value,
      input logic               relu,
      input int unsigned        shift
   );
      logic signed [31:0] r;
      logic signed [31:0] s;
      r = (relu && value < 0) ? '0 : value;
      s = r >>> shift;
      if (relu) begin
         // A ReLU result is never negative, so only the top bound applies.
         if (s > U8_MAX) return BYTE_W'(U8_MAX);
      end else if (s > S8_MAX) begin
         return BYTE_W'(S8_MAX);
      end else if (s < S8_MIN) begin
         return BYTE_W'(S8_MIN);
      end
      return s[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous word FIFO with a registered read port. A push and a pop in the
// same cycle both proceed, including when the FIFO is full.
module npu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !clear && !empty;
   assign do_push = push && !clear && (!full || do_pop);

   // NOTE: storage has no reset; the pointers alone decide which entries are
   // valid, so the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= do_pop;
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            rd_data <= mem[rd_ptr];
         end
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/conv_out_buffer.sv
// Requantises the conv result stream to bytes, packs four bytes little-endian
// per word and queues the words for the host read path.
module conv_out_buffer
   import npu_pkg::*;
#(
   parameter int DATA_W  = 24,
   parameter int DEPTH   = 32,
   parameter int SHIFT_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   relu_en,
   input  logic [SHIFT_W-1:0]     shift,
   input  logic                   flush,
   input  logic                   rd_en,
   output logic [WORD_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic [1:0]             lane_cnt,
   output logic                   overflow
);

   logic signed [31:0] data_ext;
   logic [BYTE_W-1:0]  q;
   logic [WORD_W-1:0]  partial;
   logic [WORD_W-1:0]  word_next;
   logic               push;

   assign data_ext = 32'(signed'(in_data));
   assign q        = requant(data_ext, relu_en, 32'(shift));

   // NOTE: the default is assigned first so no path leaves word_next unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      word_next = partial;
      if (in_valid) word_next[int'(lane_cnt)*BYTE_W +: BYTE_W] = q;
   end

   // A flush that coincides with a new byte carries that byte in the word.
   assign push = !clear &&
                 ((in_valid && lane_cnt == 2'(LANES-1)) ||
                  (flush && (lane_cnt != '0 || in_valid)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         partial  <= '0;
         lane_cnt <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         partial  <= '0;
         lane_cnt <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         partial  <= '0;
         lane_cnt <= '0;
         // A same-cycle pop frees the slot, so only an unpopped full FIFO drops.
         if (full && !rd_en) overflow <= 1'b1;
      end else if (in_valid) begin
         partial  <= word_next;
         lane_cnt <= lane_cnt + 2'd1;
      end
   end

   npu_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .push     (push),
      .wr_data  (word_next),
      .pop      (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .empty    (empty),
      .full     (full)
   );

endmodule

// File: tb/tb_conv_out_buffer.sv
// Self-checking bench for conv_out_buffer: requant vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_conv_out_buffer;

   localparam int DATA_W  = 24;
   localparam int DEPTH   = 32;
   localparam int SHIFT_W = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   clear;
   logic                   in_valid;
   logic [DATA_W-1:0]      in_data;
   logic                   relu_en;
   logic [SHIFT_W-1:0]     shift;
   logic                   flush;
   logic                   rd_en;
   logic [31:0]            rd_data;
   logic                   rd_valid;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;
   logic [1:0]             lane_cnt;
   logic                   overflow;

   always #5 clk = ~clk;

   conv_out_buffer #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .in_valid (in_valid),
      .in_data  (in_data),
      .relu_en  (relu_en),
      .shift    (shift),
      .flush    (flush),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .lane_cnt (lane_cnt),
      .overflow (overflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: pending bytes, queued words, last read word.
   logic [7:0]  m_pend[$];
   logic [31:0] m_fifo[$];
   logic [31:0] m_rd_data;
   bit          m_rd_valid;
   bit          m_ovf;

   typedef struct {
      int         data;
      bit         relu;
      int         sh;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sdata(input logic [DATA_W-1:0] d);
      return d[DATA_W-1] ? int'(d) - (1 << DATA_W) : int'(d);
   endfunction

   // Floor division by 2^sh, then clamp: arithmetic form of the requant rule.
   function automatic logic [7:0] ref_q(input int d, input bit relu, input int sh);
      longint v;
      longint p;
      longint s;
      v = d;
      if (relu && v < 0) v = 0;
      p = longint'(1) << sh;
      if (v >= 0) s = v / p;
      else        s = -((-v + p - 1) / p);
      if (relu) begin
         if (s > 255) s = 255;
      end else begin
         if (s > 127)  s = 127;
         if (s < -128) s = -128;
      end
      return s[7:0];
   endfunction

   task automatic model_reset();
      m_pend.delete();
      m_fifo.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
   endtask

   task automatic model_cycle();
      bit          pop_now;
      logic [31:0] w;
      if (clear) begin
         m_pend.delete();
         m_fifo.delete();
         m_ovf      = 1'b0;
         m_rd_valid = 1'b0;
         return;
      end
      pop_now    = rd_en && m_fifo.size() > 0;
      m_rd_valid = pop_now;
      if (pop_now) m_rd_data = m_fifo.pop_front();
      if (in_valid) m_pend.push_back(ref_q(sdata(in_data), relu_en, int'(shift)));
      if (m_pend.size() == 4 || (flush && m_pend.size() > 0)) begin
         w = '0;
         foreach (m_pend[i]) w[i*8 +: 8] = m_pend[i];
         if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
         else                       m_ovf = 1'b1;
         m_pend.delete();
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
      check({tag, ".rd_data"},  rd_data,       m_rd_data);
      check({tag, ".count"},    32'(count),    32'(m_fifo.size()));
      check({tag, ".empty"},    32'(empty),    32'(m_fifo.size() == 0));
      check({tag, ".full"},     32'(full),     32'(m_fifo.size() == DEPTH));
      check({tag, ".lane_cnt"}, 32'(lane_cnt), 32'(m_pend.size()));
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   task automatic idle();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      relu_en  = 1'b0;
      shift    = '0;
      flush    = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic tick(input string tag);
      model_cycle();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic feed(input int d, input bit relu, input int sh, input bit fl,
                       input bit rd, input string tag);
      in_valid = 1'b1;
      in_data  = DATA_W'(d);
      relu_en  = relu;
      shift    = SHIFT_W'(sh);
      flush    = fl;
      rd_en    = rd;
      tick(tag);
      idle();
   endtask

   task automatic do_flush(input string tag);
      flush = 1'b1;
      tick(tag);
      idle();
   endtask

   task automatic do_pop(input string tag);
      rd_en = 1'b1;
      tick(tag);
      idle();
   endtask

   task automatic do_clear(input string tag);
      clear = 1'b1;
      tick(tag);
      idle();
   endtask

   initial begin
      vecs[0]  = '{5,          1'b1, 0,  8'h05};
      vecs[1]  = '{-3,         1'b1, 0,  8'h00};
      vecs[2]  = '{300,        1'b1, 0,  8'hFF};
      vecs[3]  = '{127,        1'b1, 0,  8'h7F};
      vecs[4]  = '{-4096,      1'b0, 4,  8'h80};
      vecs[5]  = '{256,        1'b0, 4,  8'h10};
      vecs[6]  = '{-1,         1'b0, 4,  8'hFF};
      vecs[7]  = '{2047,       1'b0, 4,  8'h7F};
      vecs[8]  = '{-200,       1'b0, 0,  8'h80};
      vecs[9]  = '{8388607,    1'b0, 31, 8'h00};
      vecs[10] = '{-8388608,   1'b0, 31, 8'hFF};
      vecs[11] = '{-8388608,   1'b0, 22, 8'hFE};
      vecs[12] = '{1000,       1'b1, 2,  8'hFA};
      vecs[13] = '{1024,       1'b1, 2,  8'hFF};
      vecs[14] = '{-7,         1'b0, 1,  8'hFC};

      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      check_all("reset");
      check("reset.empty_const", 32'(empty), 32'd1);

      // Requant table: each byte is flushed alone and read back in lane 0.
      foreach (vecs[i]) begin
         feed(vecs[i].data, vecs[i].relu, vecs[i].sh, 1'b1, 1'b0, "vec_push");
         do_pop("vec_pop");
         check($sformatf("vec[%0d]", i), rd_data, {24'h0, vecs[i].exp});
      end

      // ReLU, shift 0: one full word.
      feed(5,    1, 0, 0, 0, "relu_w");
      feed(-3,   1, 0, 0, 0, "relu_w");
      feed(300,  1, 0, 0, 0, "relu_w");
      feed(127,  1, 0, 0, 0, "relu_w");
      check("relu_w.count", 32'(count), 32'd1);
      check("relu_w.lane",  32'(lane_cnt), 32'd0);
      do_pop("relu_w_pop");
      check("relu_w.word", rd_data, 32'h7FFF0005);

      // Signed, shift 4.
      feed(-4096, 0, 4, 0, 0, "sgn_w");
      feed(256,   0, 4, 0, 0, "sgn_w");
      feed(-1,    0, 4, 0, 0, "sgn_w");
      feed(2047,  0, 4, 0, 0, "sgn_w");
      do_pop("sgn_w_pop");
      check("sgn_w.word", rd_data, 32'h7FFF1080);

      // Partial flush, then an empty flush that must not push.
      feed(1, 0, 0, 0, 0, "pflush");
      feed(2, 0, 0, 0, 0, "pflush");
      do_flush("pflush");
      do_flush("pflush_empty");
      check("pflush_empty.count", 32'(count), 32'd1);
      do_pop("pflush_pop");
      check("pflush.word", rd_data, 32'h00000201);

      // Overflow: 33 words without pops, then drain in order.
      for (int i = 0; i < DEPTH + 1; i++) feed(i, 0, 0, 1, 0, "fill");
      check("ovf.full", 32'(full), 32'd1);
      check("ovf.flag", 32'(overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         do_pop("drain");
         check($sformatf("drain[%0d]", i), rd_data, 32'(i));
         check("drain.rd_valid", 32'(rd_valid), 32'd1);
      end
      check("drain.empty", 32'(empty), 32'd1);
      do_pop("pop_empty");
      check("pop_empty.rd_valid", 32'(rd_valid), 32'd0);
      do_clear("clr_ovf");
      check("clr_ovf.flag", 32'(overflow), 32'd0);

      // Full FIFO: the 4th byte arrives with a pop, so the word is accepted.
      for (int i = 0; i < DEPTH; i++) feed(64 + i, 0, 0, 1, 0, "fill2");
      feed(1, 0, 0, 0, 0, "push_pop");
      feed(2, 0, 0, 0, 0, "push_pop");
      feed(3, 0, 0, 0, 0, "push_pop");
      feed(4, 0, 0, 0, 1, "push_pop");
      check("push_pop.count", 32'(count), 32'(DEPTH));
      check("push_pop.ovf",   32'(overflow), 32'd0);
      check("push_pop.first", rd_data, 32'd64);
      for (int i = 0; i < DEPTH; i++) do_pop("drain2");
      check("push_pop.last", rd_data, 32'h04030201);

      // Asynchronous reset with partial state present.
      for (int i = 0; i < 3; i++) feed(i + 10, 0, 0, 1, 0, "pre_rst");
      feed(7, 0, 0, 0, 0, "pre_rst");
      feed(8, 0, 0, 0, 0, "pre_rst");
      check("pre_rst.count", 32'(count), 32'd3);
      check("pre_rst.lane",  32'(lane_cnt), 32'd2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      check("async_rst.count", 32'(count), 32'd0);
      check("async_rst.lane",  32'(lane_cnt), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = DATA_W'(42);
      tick("clr_in");
      idle();
      check("clr_in.lane", 32'(lane_cnt), 32'd0);

      // Randomized traffic in phases of increasing pop rate.
      for (int i = 0; i < 3000; i++) begin
         int rd_pct;
         rd_pct   = (i < 1000) ? 12 : ((i < 2000) ? 50 : 88);
         in_valid = ($urandom_range(0, 99) < 80);
         in_data  = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom)
                                                : DATA_W'($urandom_range(0, 1023) - 512);
         relu_en  = 1'($urandom_range(0, 1));
         shift    = ($urandom_range(0, 3) == 0) ? SHIFT_W'($urandom_range(0, 31))
                                                : SHIFT_W'($urandom_range(0, 6));
         flush    = ($urandom_range(0, 7) == 0);
         rd_en    = ($urandom_range(0, 99) < rd_pct);
         clear    = ($urandom_range(0, 299) == 0);
         tick("rand");
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
